// File: rtl/mem_nlane.sv
// mem_nlane: multi-lane pseudo-dual-port memory.
// Each write or read beat moves LANES consecutive words. Addresses wrap
// modulo HEIGHT. Write lanes can be masked individually. Read and write
// pointers advance automatically. Read data is registered and has a valid flag.
// Optional macro MEM_NLANE_WRITE_FORWARD_EN: when a read and a write touch the
// same word in the same cycle, the read returns the new write data. Without
// it, the read returns the old contents (read-before-write).
// Outside synthesis, area_acc and energy_acc keep the accounting figures.
module mem_nlane #(
  parameter int WIDTH                = 16,
  parameter int HEIGHT               = 64,
  parameter int LANES                = 3,
  parameter int USED_AS_EXTERNAL_MEM = 0
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       wr_en,
  input  logic                       wr_start,
  input  logic [$clog2(HEIGHT)-1:0]  wr_addr,
  input  logic [LANES-1:0]           wr_mask,
  input  logic [LANES*WIDTH-1:0]     wr_data,
  input  logic                       rd_en,
  input  logic                       rd_start,
  input  logic [$clog2(HEIGHT)-1:0]  rd_addr,
  output logic [LANES*WIDTH-1:0]     rd_data,
  output logic                       rd_valid,
  output logic [$clog2(HEIGHT)-1:0]  wr_ptr,
  output logic [$clog2(HEIGHT)-1:0]  rd_ptr
);

  localparam int unsigned AW = $clog2(HEIGHT);
  typedef logic [AW:0] ext_t;
  localparam ext_t H_EXT = ext_t'(HEIGHT);
  localparam ext_t L_EXT = ext_t'(LANES);

  // If two lanes of one beat mapped to the same word, that beat would be ambiguous.
  if (LANES > HEIGHT) begin : g_lane_collision
    $fatal(1, "mem_nlane: LANES (%0d) exceeds HEIGHT (%0d)", LANES, HEIGHT);
  end

  // Every value passed here is below 2*HEIGHT: a base address plus at most
  // LANES, or a raw port address below 2**AW. One conditional subtraction is
  // therefore enough, and HEIGHT does not need to be a power of two.
  function automatic logic [AW-1:0] wrap(input ext_t v);
    return AW'((v >= H_EXT) ? v - H_EXT : v);
  endfunction

  logic [WIDTH-1:0]       mem [HEIGHT];
  logic [AW-1:0]          wr_base, rd_base;
  logic [AW-1:0]          wr_ptr_nxt, rd_ptr_nxt;
  logic [AW-1:0]          wr_lane_addr [LANES];
  logic [AW-1:0]          rd_lane_addr [LANES];
  logic [LANES*WIDTH-1:0] rd_word;

  // Select the base addresses and compute the per-lane wrapped addresses.
  always_comb begin
    wr_base    = wr_start ? wrap({1'b0, wr_addr}) : wr_ptr;
    rd_base    = rd_start ? wrap({1'b0, rd_addr}) : rd_ptr;
    wr_ptr_nxt = wrap({1'b0, wr_base} + L_EXT);
    rd_ptr_nxt = wrap({1'b0, rd_base} + L_EXT);
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_lane_addr[i] = wrap({1'b0, wr_base} + ext_t'(i));
      rd_lane_addr[i] = wrap({1'b0, rd_base} + ext_t'(i));
    end
  end

  // Gather the read word for each lane, with same-cycle write forwarding if enabled.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rd_word[i*WIDTH +: WIDTH] = mem[rd_lane_addr[i]];
`ifdef MEM_NLANE_WRITE_FORWARD_EN
      // Write lane addresses are distinct, so at most one write lane can match.
      for (int unsigned j = 0; j < LANES; j++) begin
        if (wr_en && wr_mask[j] && (wr_lane_addr[j] == rd_lane_addr[i]))
          rd_word[i*WIDTH +: WIDTH] = wr_data[j*WIDTH +: WIDTH];
      end
`endif
    end
  end

  // Storage write. Only masked-in lanes are stored. Storage has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_mask[i])
          mem[wr_lane_addr[i]] <= wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer, read-data and valid registers with asynchronous reset.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr_nxt;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_ptr  <= rd_ptr_nxt;
        rd_data <= rd_word;
      end
    end
  end

`ifndef SYNTHESIS
  localparam real SCALE     = (USED_AS_EXTERNAL_MEM != 0) ? 1.0 : 0.1;
  localparam real AREA_COST = (USED_AS_EXTERNAL_MEM != 0) ? 0.0 :
                              ((HEIGHT < 128) ? 17.0 : 1.0) * WIDTH * HEIGHT;

  real area_acc   = 0.0;
  real energy_acc = 0.0;

  // Latch the area figure once, at the first clock edge.
  always_ff @(posedge clk) begin
    area_acc <= (area_acc == 0.0) ? AREA_COST : area_acc;
  end

  // Add the energy of each beat. A fully masked write beat costs nothing.
  always_ff @(posedge clk) begin
    if (arst_n_in)
      energy_acc <= energy_acc
                  + (rd_en ? real'(LANES * WIDTH) * SCALE : 0.0)
                  + (wr_en ? real'($countones(wr_mask) * WIDTH) * SCALE : 0.0);
  end

  // A port address of HEIGHT or more is possible only when HEIGHT is not a power of two.
  if (HEIGHT != (1 << AW)) begin : g_addr_check
    // Report out-of-range start addresses. The hardware still reduces them modulo HEIGHT.
    always_ff @(posedge clk) begin
      if (arst_n_in && wr_en && wr_start && ({1'b0, wr_addr} >= H_EXT))
        $error("mem_nlane: wr_addr %0d >= HEIGHT %0d", wr_addr, HEIGHT);
      if (arst_n_in && rd_en && rd_start && ({1'b0, rd_addr} >= H_EXT))
        $error("mem_nlane: rd_addr %0d >= HEIGHT %0d", rd_addr, HEIGHT);
    end
  end
`endif

endmodule

// File: tb/tb_mem_nlane.sv
// Testbench for mem_nlane with default parameters (WIDTH=16, HEIGHT=64, LANES=3).
// A modulo-arithmetic reference model predicts the pointers, rd_valid and rd_data.
// Directed scenarios add hand-computed literal expectations.
module tb_mem_nlane;

  localparam int W = 16;
  localparam int H = 64;
  localparam int L = 3;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          wr_en = 1'b0, wr_start = 1'b0, rd_en = 1'b0, rd_start = 1'b0;
  logic [5:0]    wr_addr = '0, rd_addr = '0;
  logic [L-1:0]  wr_mask = '0;
  logic [L*W-1:0] wr_data = '0;
  logic [L*W-1:0] rd_data;
  logic          rd_valid;
  logic [5:0]    wr_ptr, rd_ptr;

  mem_nlane #(.WIDTH(W), .HEIGHT(H), .LANES(L), .USED_AS_EXTERNAL_MEM(0)) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .wr_en(wr_en), .wr_start(wr_start), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_en(rd_en), .rd_start(rd_start), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_mem [H];
  bit           m_known [H];
  int           m_wr_ptr = 0, m_rd_ptr = 0;
  bit           m_valid = 0;
  logic [W-1:0] m_data [L];
  bit           m_dknown [L];

  initial begin
    for (int i = 0; i < H; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    for (int i = 0; i < L; i++) begin m_data[i] = '0; m_dknown[i] = 1; end
  end

  always @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      m_wr_ptr = 0; m_rd_ptr = 0; m_valid = 0;
      for (int i = 0; i < L; i++) begin m_data[i] = '0; m_dknown[i] = 1; end
    end else begin
      int wb, rb, a;
      wb = wr_start ? int'(wr_addr) % H : m_wr_ptr;
      rb = rd_start ? int'(rd_addr) % H : m_rd_ptr;
      if (rd_en) begin
        for (int i = 0; i < L; i++) begin
          a = (rb + i) % H;
          m_data[i] = m_mem[a];
          m_dknown[i] = m_known[a];
`ifdef MEM_NLANE_WRITE_FORWARD_EN
          for (int j = 0; j < L; j++)
            if (wr_en && wr_mask[j] && ((wb + j) % H == a)) begin
              m_data[i] = wr_data[j*W +: W];
              m_dknown[i] = 1;
            end
`endif
        end
        m_rd_ptr = (rb + L) % H;
      end
      m_valid = rd_en;
      if (wr_en) begin
        for (int j = 0; j < L; j++)
          if (wr_mask[j]) begin
            m_mem[(wb + j) % H] = wr_data[j*W +: W];
            m_known[(wb + j) % H] = 1;
          end
        m_wr_ptr = (wb + L) % H;
      end
    end
  end

  // Compare the DUT against the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (started && arst_n_in) begin
      check("rd_valid", 64'(rd_valid), 64'(m_valid));
      check("wr_ptr", 64'(wr_ptr), 64'(m_wr_ptr));
      check("rd_ptr", 64'(rd_ptr), 64'(m_rd_ptr));
      for (int i = 0; i < L; i++)
        if (m_dknown[i]) check("rd_data_lane", 64'(rd_data[i*W +: W]), 64'(m_data[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input bit we, input bit ws, input int wa, input logic [L-1:0] wm,
                      input logic [L*W-1:0] wd, input bit re, input bit rs, input int ra);
    @(negedge clk);
    #1;
    wr_en = we; wr_start = ws; wr_addr = 6'(wa); wr_mask = wm; wr_data = wd;
    rd_en = re; rd_start = rs; rd_addr = 6'(ra);
  endtask

  task automatic idle();
    beat(0, 0, 0, '0, '0, 0, 0, 0);
  endtask

  logic [L*W-1:0] bd [4];
  real e0, e1;

  initial begin
    // reset state
    #2;
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_wr_ptr", 64'(wr_ptr), 64'd0);
    check("reset_rd_ptr", 64'(rd_ptr), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);
    @(negedge clk); #1; arst_n_in = 1'b1; started = 1'b1;

    // basic write then read
    beat(1, 1, 0, 3'b111, {16'd3, 16'd2, 16'd1}, 0, 0, 0);
    beat(0, 0, 0, '0, '0, 1, 1, 0);
    idle();
    check("basic_valid", 64'(rd_valid), 64'd1);
    check("basic_data", 64'(rd_data), 64'h0003_0002_0001);
    check("basic_wr_ptr", 64'(wr_ptr), 64'd3);
    check("basic_rd_ptr", 64'(rd_ptr), 64'd3);

    // wrap past HEIGHT-1
    beat(1, 1, 62, 3'b111, {16'hC, 16'hB, 16'hA}, 0, 0, 0);
    idle();
    check("wrap_wr_ptr", 64'(wr_ptr), 64'd1);
    beat(0, 0, 0, '0, '0, 1, 1, 62);
    idle();
    check("wrap_data", 64'(rd_data), 64'h000C_000B_000A);
    check("wrap_rd_ptr", 64'(rd_ptr), 64'd1);

    // burst of four write beats from address 10
    for (int k = 0; k < 4; k++) begin
      bd[k] = {16'($urandom), 16'($urandom), 16'($urandom)};
      beat(1, k == 0, 10, 3'b111, bd[k], 0, 0, 0);
      idle();
      check("burst_wr_ptr", 64'(wr_ptr), 64'(13 + 3 * k));
    end
    for (int k = 0; k < 4; k++) begin
      beat(0, 0, 0, '0, '0, 1, k == 0, 10);
      if (k > 0) check("burst_rd_data", 64'(rd_data), 64'(bd[k-1]));
    end
    idle();
    check("burst_rd_last", 64'(rd_data), 64'(bd[3]));
    check("burst_rd_ptr", 64'(rd_ptr), 64'd22);

    // masked write and its energy cost
    beat(1, 1, 5, 3'b111, {16'hAAAA, 16'hAAAA, 16'hAAAA}, 0, 0, 0);
    idle();
    e0 = dut.energy_acc;
    beat(1, 1, 5, 3'b010, {16'd1, 16'd2, 16'd3}, 0, 0, 0);
    idle();
    e1 = dut.energy_acc;
    check("mask_energy_x10", 64'($rtoi((e1 - e0) * 10.0 + 0.5)), 64'd16);
    beat(0, 0, 0, '0, '0, 1, 1, 5);
    idle();
    check("mask_data", 64'(rd_data), 64'hAAAA_0002_AAAA);

    // same-cycle read and write at address 20
    beat(1, 1, 20, 3'b111, '0, 0, 0, 0);
    beat(1, 1, 20, 3'b111, {16'd9, 16'd9, 16'd9}, 1, 1, 20);
    beat(0, 0, 0, '0, '0, 1, 1, 20);
`ifdef MEM_NLANE_WRITE_FORWARD_EN
    check("rw_same_cycle", 64'(rd_data), 64'h0009_0009_0009);
`else
    check("rw_same_cycle", 64'(rd_data), 64'h0);
`endif
    idle();
    check("rw_after", 64'(rd_data), 64'h0009_0009_0009);

    // asynchronous reset in the middle of a read burst
    beat(0, 0, 0, '0, '0, 1, 1, 24);
    beat(0, 0, 0, '0, '0, 1, 0, 0);
    beat(0, 0, 0, '0, '0, 1, 0, 0);
    check("burst_ptr_before_reset", 64'(rd_ptr), 64'd30);
    #2 arst_n_in = 1'b0;
    #1;
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_rd_ptr", 64'(rd_ptr), 64'd0);
    check("async_wr_ptr", 64'(wr_ptr), 64'd0);
    idle();
    @(negedge clk); #1; arst_n_in = 1'b1;
    beat(0, 0, 0, '0, '0, 1, 1, 5);
    idle();
    check("persist_after_reset", 64'(rd_data), 64'hAAAA_0002_AAAA);

    // randomized traffic checked by the model
    for (int n = 0; n < 400; n++) begin
      beat($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, H - 1),
           L'($urandom), {16'($urandom), 16'($urandom), 16'($urandom)},
           $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, H - 1));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
